// File: rtl/rv32_imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : rv32_imem_loader_if
// Description : Byte-stream, instruction-memory write and status bundle
//               between a program source and rv32_imem_loader.
// Revision    : 1.0  initial release
// ============================================================================

interface rv32_imem_loader_if #(
  parameter int IMEM_AW = 12
);
  logic               start;
  logic [7:0]         byte_data;
  logic               byte_valid;
  logic               byte_ready;
  logic [IMEM_AW-1:0] rv32_io_imem_addr;
  logic [31:0]        rv32_io_imem_data;
  logic               rv32_io_imem_w_en;
  logic               rv32_io_program;
  logic               done;
  logic               err;
  logic [IMEM_AW:0]   words_loaded;

  // Program source side: drives the byte stream, observes the loader.
  modport master (
    output start, byte_data, byte_valid,
    input  byte_ready, rv32_io_imem_addr, rv32_io_imem_data, rv32_io_imem_w_en,
    input  rv32_io_program, done, err, words_loaded
  );

  // Loader side.
  modport slave (
    input  start, byte_data, byte_valid,
    output byte_ready, rv32_io_imem_addr, rv32_io_imem_data, rv32_io_imem_w_en,
    output rv32_io_program, done, err, words_loaded
  );
endinterface

`default_nettype wire

// File: rtl/rv32_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : rv32_imem_loader
// Description : Loads a length-prefixed little-endian byte stream into the
//               core instruction memory, holding the core in program mode.
// Revision    : 1.0  initial release
// ============================================================================

module rv32_imem_loader #(
  parameter int IMEM_DEPTH = 4096,
  parameter int IMEM_AW    = 12
) (
  input  logic              rv32_io_clk,
  input  logic              rv32_io_rst,
  rv32_imem_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [31:0] C_DEPTH = 32'(IMEM_DEPTH);

  state_t             state_q;
  logic [1:0]         byte_cnt_q;
  logic [31:0]        len_q;
  logic [23:0]        word_q;
  logic [IMEM_AW:0]   words_loaded_q;
  logic               byte_ready_q;
  logic               w_en_q;
  logic [IMEM_AW-1:0] addr_q;
  logic [31:0]        data_q;
  logic               program_q;
  logic               done_q;
  logic               err_q;

  logic               accept_d;
  logic               last_byte_d;
  logic [31:0]        len_d;
  logic [31:0]        word_d;
  logic [IMEM_AW:0]   words_loaded_d;

  assign accept_d       = bus.byte_valid & byte_ready_q;
  assign last_byte_d    = (byte_cnt_q == 2'd3);
  // Fully assembled values as of the 4th byte, used for the same-edge decision.
  assign len_d          = {bus.byte_data, len_q[23:0]};
  assign word_d         = {bus.byte_data, word_q};
  assign words_loaded_d = words_loaded_q + (IMEM_AW+1)'(1);

  always_ff @(posedge rv32_io_clk) begin
    if (rv32_io_rst) begin
      state_q        <= S_IDLE;
      byte_cnt_q     <= 2'd0;
      len_q          <= 32'd0;
      word_q         <= 24'd0;
      words_loaded_q <= '0;
      byte_ready_q   <= 1'b0;
      w_en_q         <= 1'b0;
      addr_q         <= '0;
      data_q         <= 32'd0;
      program_q      <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      w_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= 32'd0;

      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            err_q          <= 1'b0;
            words_loaded_q <= '0;
            byte_cnt_q     <= 2'd0;
            len_q          <= 32'd0;
            word_q         <= 24'd0;
            byte_ready_q   <= 1'b1;
            program_q      <= 1'b1;
            state_q        <= S_HDR;
          end
        end

        S_HDR: begin
          if (accept_d) begin
            byte_cnt_q                  <= byte_cnt_q + 2'd1;
            len_q[8*byte_cnt_q +: 8]    <= bus.byte_data;
            if (last_byte_d) begin
              if ((len_d == 32'd0) || (len_d > C_DEPTH)) begin
                err_q        <= 1'b1;
                byte_ready_q <= 1'b0;
                program_q    <= 1'b0;
                state_q      <= S_ERR;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end

        S_DATA: begin
          if (accept_d) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (!last_byte_d) begin
              word_q[8*byte_cnt_q +: 8] <= bus.byte_data;
            end else begin
              byte_ready_q <= 1'b0;
              // Backstop: a write past the memory end aborts the load instead.
              if (32'(words_loaded_q) >= C_DEPTH) begin
                err_q     <= 1'b1;
                program_q <= 1'b0;
                state_q   <= S_ERR;
              end else begin
                w_en_q  <= 1'b1;
                addr_q  <= words_loaded_q[IMEM_AW-1:0];
                data_q  <= word_d;
                state_q <= S_WR;
              end
            end
          end
        end

        S_WR: begin
          words_loaded_q <= words_loaded_d;
          if (32'(words_loaded_d) == len_q) begin
            done_q    <= 1'b1;
            program_q <= 1'b0;
            state_q   <= S_DONE;
          end else begin
            byte_ready_q <= 1'b1;
            state_q      <= S_DATA;
          end
        end

        S_DONE: state_q <= S_IDLE;

        S_ERR: state_q <= S_IDLE;

        default: begin
          byte_ready_q <= 1'b0;
          program_q    <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready        = byte_ready_q;
  assign bus.rv32_io_imem_w_en = w_en_q;
  assign bus.rv32_io_imem_addr = addr_q;
  assign bus.rv32_io_imem_data = data_q;
  assign bus.rv32_io_program   = program_q;
  assign bus.done              = done_q;
  assign bus.err               = err_q;
  assign bus.words_loaded      = words_loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32_imem_loader
// Description : Directed self-checking bench for rv32_imem_loader.
// Revision    : 1.0  initial release
// ============================================================================

module tb_rv32_imem_loader;

  localparam int IMEM_DEPTH = 4096;
  localparam int IMEM_AW    = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_imem_loader_if #(.IMEM_AW(IMEM_AW)) bus ();

  rv32_imem_loader #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .IMEM_AW    (IMEM_AW)
  ) dut (
    .rv32_io_clk (clk),
    .rv32_io_rst (rst),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [IMEM_AW-1:0] wr_addr [$];
  logic [31:0]        wr_data [$];
  int rdy_viol  = 0;
  int prog_viol = 0;
  int zero_viol = 0;
  int done_cnt  = 0;

  logic [7:0] prog2 [12] = '{8'h02, 8'h00, 8'h00, 8'h00,
                             8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00};
  int gaps [12] = '{0, 2, 1, 3, 0, 1, 0, 2, 1, 0, 3, 1};

  // Passive observer of the write port and done strobe.
  always @(negedge clk) begin
    if (bus.rv32_io_imem_w_en === 1'b1) begin
      wr_addr.push_back(bus.rv32_io_imem_addr);
      wr_data.push_back(bus.rv32_io_imem_data);
      if (bus.byte_ready !== 1'b0) rdy_viol++;
      if (bus.rv32_io_program !== 1'b1) prog_viol++;
    end
    if (bus.rv32_io_imem_w_en === 1'b0 &&
        (bus.rv32_io_imem_addr !== '0 || bus.rv32_io_imem_data !== 32'd0)) zero_viol++;
    if (bus.done === 1'b1) done_cnt++;
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    bus.byte_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL byte_timeout: byte_ready=%b after %0d cycles, required 1", bus.byte_ready, n);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.byte_ready, bus.rv32_io_imem_w_en, bus.rv32_io_program, bus.done, bus.err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: rdy/wen/prog/done/err=%b required 00000",
               {bus.byte_ready, bus.rv32_io_imem_w_en, bus.rv32_io_program, bus.done, bus.err});
    end
    total++;
    if (bus.rv32_io_imem_addr !== '0 || bus.rv32_io_imem_data !== 32'd0 || bus.words_loaded !== '0) begin
      bad++;
      $display("FAIL reset_bus: addr=%h data=%h words=%0d required 0/0/0",
               bus.rv32_io_imem_addr, bus.rv32_io_imem_data, bus.words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.byte_ready !== 1'b0 || bus.rv32_io_program !== 1'b0) begin
      bad++;
      $display("FAIL idle_outputs: byte_ready=%b program=%b required 0/0", bus.byte_ready, bus.rv32_io_program);
    end
  endtask

  task automatic test_basic_load();
    int n0;
    int d0;
    n0 = wr_data.size();
    d0 = done_cnt;
    do_start();
    total++;
    if (bus.byte_ready !== 1'b1 || bus.rv32_io_program !== 1'b1) begin
      bad++;
      $display("FAIL hdr_entry: byte_ready=%b program=%b required 1/1", bus.byte_ready, bus.rv32_io_program);
    end
    for (int i = 0; i < 8; i++) send_byte(prog2[i], 0);
    total++;
    if (bus.rv32_io_imem_w_en !== 1'b1 || bus.rv32_io_imem_addr !== 12'd0 || bus.rv32_io_imem_data !== 32'h00100513) begin
      bad++;
      $display("FAIL wr0_latency: w_en=%b addr=%h data=%h required 1/000/00100513",
               bus.rv32_io_imem_w_en, bus.rv32_io_imem_addr, bus.rv32_io_imem_data);
    end
    for (int i = 8; i < 12; i++) send_byte(prog2[i], 0);
    total++;
    if (bus.rv32_io_imem_w_en !== 1'b1 || bus.rv32_io_imem_addr !== 12'd1 ||
        bus.rv32_io_imem_data !== 32'h00200593 || bus.rv32_io_program !== 1'b1) begin
      bad++;
      $display("FAIL wr1: w_en=%b addr=%h data=%h program=%b required 1/001/00200593/1",
               bus.rv32_io_imem_w_en, bus.rv32_io_imem_addr, bus.rv32_io_imem_data, bus.rv32_io_program);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.rv32_io_program !== 1'b0 || bus.words_loaded !== 13'd2 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle: done=%b program=%b words=%0d err=%b required 1/0/2/0",
               bus.done, bus.rv32_io_program, bus.words_loaded, bus.err);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b0 || bus.byte_ready !== 1'b0 || wr_data.size() - n0 != 2 || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL after_done: done=%b byte_ready=%b writes=%0d dones=%0d required 0/0/2/1",
               bus.done, bus.byte_ready, wr_data.size() - n0, done_cnt - d0);
    end
  endtask

  task automatic test_zero_len();
    int n0;
    n0 = wr_data.size();
    do_start();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    total++;
    if (bus.err !== 1'b1 || bus.byte_ready !== 1'b0 || bus.rv32_io_program !== 1'b0 || bus.rv32_io_imem_w_en !== 1'b0) begin
      bad++;
      $display("FAIL zero_len: err=%b byte_ready=%b program=%b w_en=%b required 1/0/0/0",
               bus.err, bus.byte_ready, bus.rv32_io_program, bus.rv32_io_imem_w_en);
    end
    @(negedge clk);
    total++;
    if (bus.err !== 1'b1 || bus.byte_ready !== 1'b0 || wr_data.size() != n0) begin
      bad++;
      $display("FAIL err_sticky: err=%b byte_ready=%b writes=%0d required 1/0/0",
               bus.err, bus.byte_ready, wr_data.size() - n0);
    end
  endtask

  task automatic test_overflow_len();
    logic [7:0] hdr [4];
    logic [7:0] one [8];
    int n0;
    hdr = '{8'h01, 8'h10, 8'h00, 8'h00};
    one = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    n0  = wr_data.size();
    do_start();
    for (int i = 0; i < 4; i++) send_byte(hdr[i], 0);
    total++;
    if (bus.err !== 1'b1 || bus.rv32_io_imem_w_en !== 1'b0) begin
      bad++;
      $display("FAIL overflow_len: err=%b w_en=%b required 1/0", bus.err, bus.rv32_io_imem_w_en);
    end
    @(negedge clk);
    do_start();
    total++;
    if (bus.err !== 1'b0 || bus.byte_ready !== 1'b1 || wr_data.size() != n0) begin
      bad++;
      $display("FAIL err_clear: err=%b byte_ready=%b writes=%0d required 0/1/0",
               bus.err, bus.byte_ready, wr_data.size() - n0);
    end
    for (int i = 0; i < 8; i++) send_byte(one[i], 1);
    total++;
    if (bus.rv32_io_imem_addr !== 12'd0 || bus.rv32_io_imem_data !== 32'h12345678) begin
      bad++;
      $display("FAIL one_word: addr=%h data=%h required 000/12345678", bus.rv32_io_imem_addr, bus.rv32_io_imem_data);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.words_loaded !== 13'd1) begin
      bad++;
      $display("FAIL one_word_done: done=%b words=%0d required 1/1", bus.done, bus.words_loaded);
    end
    @(negedge clk);
  endtask

  task automatic test_len_boundary();
    logic [7:0] hdr [4];
    hdr = '{8'h00, 8'h10, 8'h00, 8'h00};
    do_start();
    for (int i = 0; i < 4; i++) send_byte(hdr[i], 0);
    total++;
    if (bus.err !== 1'b0 || bus.byte_ready !== 1'b1 || bus.rv32_io_program !== 1'b1) begin
      bad++;
      $display("FAIL len_eq_depth: err=%b byte_ready=%b program=%b required 0/1/1",
               bus.err, bus.byte_ready, bus.rv32_io_program);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gaps();
    int n0;
    int d0;
    n0 = wr_data.size();
    d0 = done_cnt;
    do_start();
    for (int i = 0; i < 12; i++) send_byte(prog2[i], gaps[i]);
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.words_loaded !== 13'd2) begin
      bad++;
      $display("FAIL gaps_done: done=%b words=%0d required 1/2", bus.done, bus.words_loaded);
    end
    total++;
    if (wr_data.size() - n0 != 2) begin
      bad++;
      $display("FAIL gaps_count: writes=%0d required 2", wr_data.size() - n0);
    end else if (wr_addr[n0] !== 12'd0 || wr_data[n0] !== 32'h00100513 ||
                 wr_addr[n0+1] !== 12'd1 || wr_data[n0+1] !== 32'h00200593) begin
      bad++;
      $display("FAIL gaps_seq: %h@%h %h@%h required 00100513@000 00200593@001",
               wr_data[n0], wr_addr[n0], wr_data[n0+1], wr_addr[n0+1]);
    end
    @(negedge clk);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL gaps_done_pulse: dones=%0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] one [8];
    int n0;
    int d0;
    one = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    n0  = wr_data.size();
    d0  = done_cnt;
    do_start();
    for (int i = 0; i < 10; i++) send_byte(prog2[i], 0);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.byte_ready, bus.rv32_io_imem_w_en, bus.rv32_io_program, bus.done, bus.err} !== 5'b0 ||
        bus.words_loaded !== '0 || bus.rv32_io_imem_addr !== '0 || bus.rv32_io_imem_data !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs: flags=%b words=%0d addr=%h data=%h required all 0",
               {bus.byte_ready, bus.rv32_io_imem_w_en, bus.rv32_io_program, bus.done, bus.err},
               bus.words_loaded, bus.rv32_io_imem_addr, bus.rv32_io_imem_data);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (wr_data.size() - n0 != 1 || done_cnt != d0) begin
      bad++;
      $display("FAIL mid_reset_quiet: writes=%0d dones=%0d required 1/0", wr_data.size() - n0, done_cnt - d0);
    end
    do_start();
    for (int i = 0; i < 8; i++) send_byte(one[i], 0);
    total++;
    if (bus.rv32_io_imem_w_en !== 1'b1 || bus.rv32_io_imem_addr !== 12'd0 || bus.rv32_io_imem_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL reload_write: w_en=%b addr=%h data=%h required 1/000/deadbeef",
               bus.rv32_io_imem_w_en, bus.rv32_io_imem_addr, bus.rv32_io_imem_data);
    end
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.words_loaded !== 13'd1) begin
      bad++;
      $display("FAIL reload_done: done=%b words=%0d required 1/1", bus.done, bus.words_loaded);
    end
    @(negedge clk);
  endtask

  task automatic test_start_during_data();
    int n0;
    n0 = wr_data.size();
    do_start();
    for (int i = 0; i < 6; i++) send_byte(prog2[i], 0);
    do_start();
    for (int i = 6; i < 12; i++) send_byte(prog2[i], 0);
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.words_loaded !== 13'd2 || bus.err !== 1'b0) begin
      bad++;
      $display("FAIL start_ignored_done: done=%b words=%0d err=%b required 1/2/0",
               bus.done, bus.words_loaded, bus.err);
    end
    total++;
    if (wr_data.size() - n0 != 2) begin
      bad++;
      $display("FAIL start_ignored_count: writes=%0d required 2", wr_data.size() - n0);
    end else if (wr_data[n0] !== 32'h00100513 || wr_data[n0+1] !== 32'h00200593 || wr_addr[n0+1] !== 12'd1) begin
      bad++;
      $display("FAIL start_ignored_seq: %h %h@%h required 00100513 00200593@001",
               wr_data[n0], wr_data[n0+1], wr_addr[n0+1]);
    end
    @(negedge clk);
  endtask

  task automatic test_invariants();
    total++;
    if (rdy_viol != 0 || prog_viol != 0 || zero_viol != 0) begin
      bad++;
      $display("FAIL invariants: ready_in_wr=%0d wr_without_program=%0d nonzero_idle_bus=%0d required 0/0/0",
               rdy_viol, prog_viol, zero_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_len();
    test_overflow_len();
    test_len_boundary();
    test_gaps();
    test_reset_mid_load();
    test_start_during_data();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
